// File: rtl/enemy_laser.sv
// enemy_laser: single enemy projectile. Spawns on a fire request, falls at a
// fixed rate, raises a one-cycle hit pulse on contact with the player ship,
// then waits out a short cooldown before it can be fired again.
//
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   fire_i, fire_x_i, fire_y_i          spawn request and spawn position
//   freeze_i                            game pause: halts motion and counters
//   player_left_i, player_right_i       player horizontal span
//   ready_o, active_o, hit_o            IDLE / FLY indication, hit pulse
//   laser_x_o, laser_top_o,
//   laser_bottom_o                      laser geometry for the display mixer
//   laser_red_o/green_o/blue_o          constant laser colour
//   state_o                             one-hot present state (debug)
module enemy_laser #(
  parameter logic [11:0] color_p         = {4'hE, 4'h2, 4'h2},
  parameter logic [9:0]  step_p          = 10'd4,
  parameter logic [19:0] move_div_p      = 20'd200000,
  parameter logic [9:0]  laser_len_p     = 10'd8,
  parameter logic [9:0]  player_top_p    = 10'd440,
  parameter logic [9:0]  player_bottom_p = 10'd460,
  parameter logic [9:0]  bottom_border_p = 10'd479,
  parameter logic [7:0]  cooldown_p      = 8'd16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       fire_i,
  input  logic [9:0] fire_x_i,
  input  logic [9:0] fire_y_i,
  input  logic       freeze_i,
  input  logic [9:0] player_left_i,
  input  logic [9:0] player_right_i,
  output logic       ready_o,
  output logic       active_o,
  output logic [9:0] laser_x_o,
  output logic [9:0] laser_top_o,
  output logic [9:0] laser_bottom_o,
  output logic       hit_o,
  output logic [3:0] laser_red_o,
  output logic [3:0] laser_green_o,
  output logic [3:0] laser_blue_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_FLY  = 4'b0010,
    ST_HIT  = 4'b0100,
    ST_COOL = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  top_q, top_d;
  logic [19:0] div_q, div_d;
  logic [7:0]  cool_q, cool_d;

  // Bottom edge and the next-move sum are kept at 11 bits so a laser near
  // the 10-bit ceiling cannot wrap around and fake a collision or a stay.
  logic [10:0] bottom_ext;
  logic [10:0] move_sum;
  logic        collide;
  logic        tick;

  assign bottom_ext = {1'b0, top_q} + {1'b0, laser_len_p} - 11'd1;
  assign move_sum   = {1'b0, top_q} + {1'b0, step_p};

  assign collide = (player_left_i <= x_q) && (x_q <= player_right_i) &&
                   (bottom_ext >= {1'b0, player_top_p}) &&
                   (top_q <= player_bottom_p);

  assign tick = (div_q == (move_div_p - 20'd1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    top_d   = top_q;
    div_d   = div_q;
    cool_d  = cool_q;
    case (state_q)
      ST_IDLE: begin
        if (fire_i && !freeze_i) begin
          x_d     = fire_x_i;
          top_d   = fire_y_i;
          div_d   = 20'd0;
          state_d = ST_FLY;
        end
      end
      ST_FLY: begin
        // Collision takes priority over a coincident move tick, so the
        // laser is never stepped past the ship on the contact cycle.
        if (!freeze_i) begin
          if (collide) begin
            state_d = ST_HIT;
          end else if (tick) begin
            if (move_sum > {1'b0, bottom_border_p}) begin
              state_d = ST_IDLE;
            end else begin
              top_d = move_sum[9:0];
              div_d = 20'd0;
            end
          end else begin
            div_d = div_q + 20'd1;
          end
        end
      end
      ST_HIT: begin
        cool_d  = cooldown_p - 8'd1;
        state_d = ST_COOL;
      end
      ST_COOL: begin
        if (!freeze_i) begin
          if (cool_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cool_d = cool_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      x_q     <= 10'd0;
      top_q   <= 10'd0;
      div_q   <= 20'd0;
      cool_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      top_q   <= top_d;
      div_q   <= div_d;
      cool_q  <= cool_d;
    end
  end

  // The hit pulse is the registered HIT state: one cycle wide, and a reset
  // leaving HIT clears it on the same edge.
  assign hit_o          = (state_q == ST_HIT);
  assign ready_o        = (state_q == ST_IDLE);
  assign active_o       = (state_q == ST_FLY);
  assign state_o        = state_q;
  assign laser_x_o      = x_q;
  assign laser_top_o    = top_q;
  assign laser_bottom_o = bottom_ext[9:0];
  assign laser_red_o    = color_p[11:8];
  assign laser_green_o  = color_p[7:4];
  assign laser_blue_o   = color_p[3:0];

endmodule

// File: tb/tb_enemy_laser.sv
// Testbench for enemy_laser: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural
// model that tracks the laser as spawn row + step * (flight ticks / divider).
module tb_enemy_laser;
  localparam int DIV  = 4;
  localparam int COOL = 3;
  localparam int STEP = 4;
  localparam int LEN  = 8;
  localparam int PT   = 440;
  localparam int PB   = 460;
  localparam int BB   = 479;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fire = 1'b0;
  logic [9:0] fx = 10'd0;
  logic [9:0] fy = 10'd0;
  logic       freeze = 1'b0;
  logic [9:0] pl = 10'd249;
  logic [9:0] pr = 10'd284;
  logic       ready, active, hit;
  logic [9:0] lx, ltop, lbot;
  logic [3:0] red, green, blue, st;

  always #5 clk = ~clk;

  enemy_laser #(.move_div_p(20'd4), .cooldown_p(8'd3)) dut (
    .clk_i(clk), .reset_i(reset), .fire_i(fire), .fire_x_i(fx), .fire_y_i(fy),
    .freeze_i(freeze), .player_left_i(pl), .player_right_i(pr),
    .ready_o(ready), .active_o(active), .laser_x_o(lx), .laser_top_o(ltop),
    .laser_bottom_o(lbot), .hit_o(hit), .laser_red_o(red),
    .laser_green_o(green), .laser_blue_o(blue), .state_o(st)
  );

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 idle, 1 flying, 2 hit, 3 cooldown.
  int m_st = 0, m_x = 0, m_y0 = 0, m_flight = 0, m_cool = 0;
  bit m_valid = 1'b0;

  function automatic int m_top();
    return m_y0 + STEP * (m_flight / DIV);
  endfunction

  always @(posedge clk) begin
    int t;
    if (reset) begin
      m_st = 0; m_x = 0; m_y0 = 0; m_flight = 0; m_cool = 0; m_valid = 1'b1;
    end else begin
      case (m_st)
        0: if (fire && !freeze) begin
          m_st = 1; m_x = int'(fx); m_y0 = int'(fy); m_flight = 0;
        end
        1: if (!freeze) begin
          t = m_top();
          if (int'(pl) <= m_x && m_x <= int'(pr) && t + LEN - 1 >= PT && t <= PB)
            m_st = 2;
          else if ((m_flight % DIV) == DIV - 1 && t + STEP > BB)
            m_st = 0;
          else
            m_flight++;
        end
        2: begin m_st = 3; m_cool = COOL - 1; end
        default: if (!freeze) begin
          if (m_cool == 0) m_st = 0; else m_cool--;
        end
      endcase
    end
    #2;
    if (hit === 1'b1) hit_cnt++;
    if (m_valid) begin
      t = m_top();
      chk("m_state", {28'd0, st}, 32'(1 << m_st));
      chk("m_ready", {31'd0, ready}, {31'd0, m_st == 0});
      chk("m_active", {31'd0, active}, {31'd0, m_st == 1});
      chk("m_hit", {31'd0, hit}, {31'd0, m_st == 2});
      chk("m_x", {22'd0, lx}, m_x);
      chk("m_top", {22'd0, ltop}, t);
      chk("m_bottom", {22'd0, lbot}, (t + LEN - 1) % 1024);
      chk("m_color", {20'd0, red, green, blue}, 32'hE22);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input int x, input int y);
    fx = 10'(x); fy = 10'(y); fire = 1'b1;
    cyc(1);
    fire = 1'b0;
  endtask

  // Directed hit flight; returns having spent the whole flight + cooldown.
  task automatic run_hit(input bit with_freeze);
    int c;
    int h;
    h = with_freeze ? 388 : 338;
    pl = 10'd249; pr = 10'd284;
    launch(260, 100);                       // now cycle N+1
    c = 1;
    chk("fire_active", {31'd0, active}, 1);
    chk("fire_top", {22'd0, ltop}, 100);
    cyc(9); c = 10;
    fire = 1'b1; fx = 10'd300;              // busy: must be ignored
    cyc(1); c = 11;
    fire = 1'b0; fx = 10'd0;
    chk("busy_x", {22'd0, lx}, 260);
    if (with_freeze) begin
      cyc(20 - c); c = 20;
      freeze = 1'b1;
      cyc(50); c = 70;
      freeze = 1'b0;
    end
    cyc(h - 1 - c);
    chk("pre_hit", {31'd0, hit}, 0);
    chk("hit_top", {22'd0, ltop}, 436);
    cyc(1);
    chk("hit_pulse", {31'd0, hit}, 1);
    cyc(1);
    chk("hit_end", {31'd0, hit}, 0);
    chk("cool_state", {28'd0, st}, 8);
    cyc(3);
    chk("cool_ready", {31'd0, ready}, 1);
  endtask

  initial begin
    int h0;
    cyc(2);
    reset = 1'b0;
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_active", {31'd0, active}, 0);
    chk("rst_hit", {31'd0, hit}, 0);
    chk("rst_state", {28'd0, st}, 1);
    chk("rst_bottom", {22'd0, lbot}, 7);
    cyc(3);

    run_hit(1'b0);
    cyc(2);
    run_hit(1'b1);

    // Fire while frozen in IDLE is dropped.
    freeze = 1'b1;
    launch(5, 5);
    cyc(1);
    chk("frz_fire_ready", {31'd0, ready}, 1);
    chk("frz_fire_active", {31'd0, active}, 0);
    freeze = 1'b0;
    cyc(2);

    // Miss.
    h0 = hit_cnt;
    launch(200, 100);
    cyc(376);
    chk("miss_top", {22'd0, ltop}, 476);
    chk("miss_active", {31'd0, active}, 1);
    cyc(3);
    chk("miss_still_fly", {31'd0, active}, 1);
    cyc(1);
    chk("miss_idle", {31'd0, ready}, 1);
    chk("miss_nohit", hit_cnt, h0);
    cyc(2);

    // Mid-flight reset.
    launch(260, 100);
    cyc(99);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mreset_ready", {31'd0, ready}, 1);
    chk("mreset_active", {31'd0, active}, 0);
    h0 = hit_cnt;
    cyc(400);
    chk("mreset_nohit", hit_cnt, h0);

    // Edge overlap: left edge column hits on the first flying cycle.
    launch(249, 433);
    chk("edge_active", {31'd0, active}, 1);
    cyc(1);
    chk("edge_hit", {31'd0, hit}, 1);
    cyc(10);
    h0 = hit_cnt;
    launch(248, 433);
    cyc(1);
    chk("edge_miss_hit", {31'd0, hit}, 0);
    cyc(60);
    chk("edge_miss_nohit", hit_cnt, h0);
    chk("edge_miss_ready", {31'd0, ready}, 1);

    // Randomized phase.
    for (int i = 0; i < 15000; i++) begin
      reset  = ($urandom_range(0, 1999) == 0);
      fire   = ($urandom_range(0, 7) == 0);
      fx     = 10'($urandom_range(200, 340));
      fy     = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                           : 10'($urandom_range(300, 470));
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      if ((i % 32) == 0) begin
        pl = 10'($urandom_range(200, 300));
        pr = pl + 10'($urandom_range(0, 60));
      end
      cyc(1);
    end
    reset = 1'b0; fire = 1'b0; freeze = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enemy_laser.md
# enemy_laser

Enemy projectile for the space-invaders datapath: the block that drives the player ship's `hit_i`. On a fire request it spawns a single vertical laser at a given enemy gun position and moves it down the screen at a fixed rate. Each cycle it checks the laser against the player's horizontal span and vertical band, and emits a one-cycle hit pulse on contact. It also exports geometry and colour for the display mixer.

## Interface
- `color_p`, `{4'hE, 4'h2, 4'h2}`, laser colour `{R,G,B}`
- `step_p`, `10'd4`, pixels moved down per move tick
- `move_div_p`, `20'd200000`, clock cycles per move tick (≥2)
- `laser_len_p`, `10'd8`, laser height in pixels (≥1)
- `player_top_p`, `10'd440`, top row of the player ship
- `player_bottom_p`, `10'd460`, bottom row of the player ship
- `bottom_border_p`, `10'd479`, last visible row
- `cooldown_p`, `8'd16`, unfrozen cycles spent in COOLDOWN after a hit (≥1)

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; synchronous, active-high
- `fire_i`  in  1  spawn request; honoured only in IDLE with `freeze_i`=0
- `fire_x_i`  in  10  spawn column (enemy gun)
- `fire_y_i`  in  10  spawn top row
- `freeze_i`  in  1  game paused (player shot/dead); halts all motion and counters
- `player_left_i`  in  10  player leftmost column
- `player_right_i`  in  10  player rightmost column
- `ready_o`  out  1  state is IDLE
- `active_o`  out  1  laser visible (FLY)
- `laser_x_o`  out  10  laser column
- `laser_top_o`  out  10  laser top row
- `laser_bottom_o`  out  10  `laser_top_o + laser_len_p - 1`
- `hit_o`  out  1  one-cycle hit pulse to the player
- `laser_red_o`, `laser_green_o`, `laser_blue_o`  out  4 each  colour nibbles of `color_p`
- `state_o`  out  4  one-hot present state, for debug

## Operation
- States, one-hot: IDLE=0001, FLY=0010, HIT=0100, COOLDOWN=1000. Any other value returns to IDLE on the next cycle.
- IDLE:
  - When `fire_i & ~freeze_i`: latch `laser_x`←`fire_x_i` and `laser_top`←`fire_y_i`, clear the divider, go to FLY.
  - Otherwise stay in IDLE.
- FLY, evaluated in this priority order each cycle:
  1. If `freeze_i`: hold everything. No collision check, no divider count.
  2. Collision when `player_left_i ≤ laser_x ≤ player_right_i` AND `laser_bottom ≥ player_top_p` AND `laser_top ≤ player_bottom_p`. Go to HIT; position is held.
  3. If the divider equals `move_div_p-1`:
     - If `laser_top + step_p > bottom_border_p` (compared at 11 bits), go to IDLE (miss).
     - Otherwise `laser_top += step_p` and the divider clears.
  4. Otherwise the divider increments.
- HIT: `hit_o`=1. Go unconditionally to COOLDOWN and load the cooldown counter with `cooldown_p-1`.
- COOLDOWN:
  - Counter decrements on unfrozen cycles.
  - At 0 with `~freeze_i`, go to IDLE.
- Ignored inputs:
  - `fire_i` outside IDLE (no queueing).
  - Collision outside FLY.
- All comparisons are unsigned 10-bit; `laser_bottom` and the move sum are computed at 11 bits to avoid wrap.

## Timing
- Reset values:
  - State IDLE; `ready_o`=1; `active_o`=0; `hit_o`=0.
  - `laser_x_o`=0, `laser_top_o`=0, `laser_bottom_o`=`laser_len_p-1`.
  - Divider and cooldown counter 0.
- `reset_i` mid-flight, mid-HIT or mid-COOLDOWN forces IDLE on the next edge and suppresses any pending `hit_o`.
- Fire latency: `fire_i` sampled in cycle N gives FLY in cycle N+1, with `laser_top_o`=`fire_y_i`.
- Motion: the k-th move is visible in cycle N+1+k·`move_div_p`, counting unfrozen cycles only.
- Hit latency: collision true in cycle M (FLY) gives `hit_o`=1 in cycle M+1 only, then COOLDOWN from M+2.
- `hit_o` is registered, exactly one cycle wide, and at most once per spawn.
- Simultaneous collision and move tick: collision wins, and no move or miss happens that cycle.
- `freeze_i` rising mid-FLY: position and divider hold; resume continues from the held divider value.
- Colour outputs are constant.

## Test plan
Benches override `move_div_p`=4 and `cooldown_p`=3.
- Reset: apply `reset_i` for 2 cycles → `ready_o`=1, `active_o`=0, `hit_o`=0, `state_o`=0001, `laser_bottom_o`=7.
- Hit: fire at cycle N with x=260, y=100, player 249..284 → FLY at N+1. `laser_top_o`=436 at N+337 (k=84). `hit_o`=1 at N+338 only. `ready_o`=1 at N+342.
- Miss: fire x=200, y=100, player 249..284 → no `hit_o`. `laser_top_o` reaches 476 at N+377, then IDLE at N+381 (476+4 > 479).
- Freeze: during the hit scenario, hold `freeze_i` for 50 cycles starting at N+20 → `laser_top_o` constant throughout. Hit arrives at N+388 instead of N+338. `fire_i` pulsed while frozen in IDLE is ignored.
- Busy and mid-flight reset: `fire_i` in FLY with a different x → `laser_x_o` unchanged. `reset_i` at N+100 → IDLE at N+101 with `active_o`=0 and no `hit_o` afterwards.
- Edge overlap: x=`player_left_i`=249, spawn y=433 → collision in the first FLY cycle (bottom 440 = `player_top_p`), `hit_o` at N+2. Same with x=248 → no hit.
